branch_redirect_ctrl: RTL and testbench

Sequences instruction-fetch addressing for the core and acts on branch resolutions from the branching unit. It owns the architectural fetch PC and issues sequential fetch requests over a valid/ready handshake. On a taken branch it redirects the PC to the branch target and pulses a pipeline flush. It traps on misaligned targets and restarts from a trap vector after acknowledge. It sits between the execute-stage branching unit and the fetch stage.

---
 rtl/branch_redirect_ctrl.sv | 101 ++++++++++
 tb/tb_branch_redirect_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/branch_redirect_ctrl.sv
// Fetch PC sequencer: issues sequential fetch requests, redirects on taken branches,
// and traps on misaligned branch targets until the handler acknowledges.
module branch_redirect_ctrl #(
    parameter int                   CPU_WIDTH = 32,
    parameter logic [CPU_WIDTH-1:0] RESET_PC  = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic                 fetch_valid,
    input  logic                 fetch_ready,
    output logic [CPU_WIDTH-1:0] fetch_pc,
    input  logic                 br_valid,
    input  logic                 br_taken,
    input  logic [CPU_WIDTH-1:0] br_pc,
    input  logic [CPU_WIDTH-1:0] br_offset,
    output logic                 flush,
    output logic                 trap_valid,
    output logic [CPU_WIDTH-1:0] trap_pc,
    input  logic                 trap_ack,
    input  logic [CPU_WIDTH-1:0] trap_vec,
    output logic [CPU_WIDTH-1:0] taken_count,
    output logic [CPU_WIDTH-1:0] branch_count
);

    typedef enum logic [1:0] {BOOT, RUN, REDIRECT, HALT} state_t;

    state_t               state, state_nxt;
    logic [CPU_WIDTH-1:0] fetch_pc_nxt, trap_pc_nxt, taken_nxt, branch_nxt;
    logic                 fetch_valid_nxt, flush_nxt, trap_valid_nxt;
    logic [CPU_WIDTH-1:0] target;

    assign target = br_pc + br_offset;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= BOOT;
            fetch_pc     <= RESET_PC;
            fetch_valid  <= 1'b0;
            flush        <= 1'b0;
            trap_valid   <= 1'b0;
            trap_pc      <= '0;
            taken_count  <= '0;
            branch_count <= '0;
        end else begin
            state        <= state_nxt;
            fetch_pc     <= fetch_pc_nxt;
            fetch_valid  <= fetch_valid_nxt;
            flush        <= flush_nxt;
            trap_valid   <= trap_valid_nxt;
            trap_pc      <= trap_pc_nxt;
            taken_count  <= taken_nxt;
            branch_count <= branch_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        fetch_pc_nxt   = fetch_pc;
        flush_nxt      = 1'b0;
        trap_valid_nxt = trap_valid;
        trap_pc_nxt    = trap_pc;
        taken_nxt      = taken_count;
        branch_nxt     = branch_count;
        case (state)
            BOOT: state_nxt = RUN;
            RUN: begin
                if (fetch_valid && fetch_ready)
                    fetch_pc_nxt = fetch_pc + CPU_WIDTH'(4);
                // A taken branch overrides the +4 of a same-cycle handshake; flush kills that request.
                if (br_valid) begin
                    branch_nxt = branch_count + 1'b1;
                    if (br_taken) begin
                        flush_nxt = 1'b1;
                        if (target[1:0] == 2'b00) begin
                            taken_nxt    = taken_count + 1'b1;
                            fetch_pc_nxt = target;
                            state_nxt    = REDIRECT;
                        end else begin
                            trap_valid_nxt = 1'b1;
                            trap_pc_nxt    = br_pc;
                            fetch_pc_nxt   = fetch_pc;
                            state_nxt      = HALT;
                        end
                    end
                end
            end
            REDIRECT: state_nxt = RUN;
            HALT: begin
                if (trap_ack) begin
                    fetch_pc_nxt   = trap_vec;
                    trap_valid_nxt = 1'b0;
                    state_nxt      = REDIRECT;
                end
            end
            default: state_nxt = BOOT;
        endcase
        // Requests are offered exactly while the registered state is RUN.
        fetch_valid_nxt = (state_nxt == RUN);
    end

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed-vector bench for branch_redirect_ctrl with hand-computed expectations.
module tb_branch_redirect_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_valid, fetch_ready;
    logic [31:0] fetch_pc;
    logic        br_valid, br_taken;
    logic [31:0] br_pc, br_offset;
    logic        flush, trap_valid;
    logic [31:0] trap_pc;
    logic        trap_ack;
    logic [31:0] trap_vec, taken_count, branch_count;

    int n_chk = 0;
    int n_err = 0;

    branch_redirect_ctrl #(.CPU_WIDTH(32), .RESET_PC(32'h0000_0100)) dut (
        .clk(clk), .rst_n(rst_n),
        .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .fetch_pc(fetch_pc),
        .br_valid(br_valid), .br_taken(br_taken), .br_pc(br_pc), .br_offset(br_offset),
        .flush(flush), .trap_valid(trap_valid), .trap_pc(trap_pc),
        .trap_ack(trap_ack), .trap_vec(trap_vec),
        .taken_count(taken_count), .branch_count(branch_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic br(input logic tk, input logic [31:0] pc, input logic [31:0] off);
        br_valid = 1'b1; br_taken = tk; br_pc = pc; br_offset = off;
    endtask

    task automatic br_clr();
        br_valid = 1'b0; br_taken = 1'b0; br_pc = '0; br_offset = '0;
    endtask

    initial begin
        fetch_ready = 1'b1; trap_ack = 1'b0; trap_vec = '0;
        br_clr();
        tick(); tick();
        chk("rst_pc", fetch_pc, 32'h100);
        chk("rst_valid", {31'b0, fetch_valid}, 32'd0);
        chk("rst_flush", {31'b0, flush}, 32'd0);
        chk("rst_trap", {31'b0, trap_valid}, 32'd0);
        chk("rst_trap_pc", trap_pc, 32'd0);
        chk("rst_taken", taken_count, 32'd0);
        chk("rst_branch", branch_count, 32'd0);

        rst_n = 1'b1;
        tick();
        chk("boot_valid", {31'b0, fetch_valid}, 32'd1);
        chk("seq0", fetch_pc, 32'h100);
        tick(); chk("seq1", fetch_pc, 32'h104);
        tick(); chk("seq2", fetch_pc, 32'h108);
        fetch_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_pc", fetch_pc, 32'h108);
            chk("stall_valid", {31'b0, fetch_valid}, 32'd1);
        end
        fetch_ready = 1'b1;
        tick(); chk("seq3", fetch_pc, 32'h10C);

        // Taken branch backward, coinciding with a handshake
        br(1'b1, 32'h200, 32'hFFFF_FFF0);
        tick(); br_clr();
        chk("tk_flush", {31'b0, flush}, 32'd1);
        chk("tk_valid", {31'b0, fetch_valid}, 32'd0);
        chk("tk_taken", taken_count, 32'd1);
        chk("tk_branch", branch_count, 32'd1);
        tick();
        chk("tk_flush_off", {31'b0, flush}, 32'd0);
        chk("tk_valid2", {31'b0, fetch_valid}, 32'd1);
        chk("tk_target", fetch_pc, 32'h1F0);
        tick(); chk("tk_seq", fetch_pc, 32'h1F4);

        // Misaligned target traps
        br(1'b1, 32'h200, 32'h6);
        tick(); br_clr();
        chk("mis_flush", {31'b0, flush}, 32'd1);
        chk("mis_trap", {31'b0, trap_valid}, 32'd1);
        chk("mis_trap_pc", trap_pc, 32'h200);
        chk("mis_valid", {31'b0, fetch_valid}, 32'd0);
        chk("mis_taken", taken_count, 32'd1);
        chk("mis_branch", branch_count, 32'd2);
        br(1'b1, 32'h0, 32'h0);
        tick(); br_clr();
        chk("halt_flush", {31'b0, flush}, 32'd0);
        chk("halt_trap", {31'b0, trap_valid}, 32'd1);
        chk("halt_br_ign", branch_count, 32'd2);
        trap_ack = 1'b1; trap_vec = 32'h80;
        tick(); trap_ack = 1'b0;
        chk("ack_trap", {31'b0, trap_valid}, 32'd0);
        chk("ack_valid", {31'b0, fetch_valid}, 32'd0);
        tick();
        chk("ack_valid2", {31'b0, fetch_valid}, 32'd1);
        chk("ack_pc", fetch_pc, 32'h80);

        // trap_ack outside HALT has no effect
        trap_ack = 1'b1; trap_vec = 32'h999;
        tick(); trap_ack = 1'b0;
        chk("ack_ign_pc", fetch_pc, 32'h84);

        // Wrap at top of the address space
        br(1'b1, 32'hFFFF_FFF0, 32'hC);
        tick(); br_clr();
        chk("wr_taken", taken_count, 32'd2);
        chk("wr_branch", branch_count, 32'd3);
        tick(); chk("wr_top", fetch_pc, 32'hFFFF_FFFC);
        tick(); chk("wr_zero", fetch_pc, 32'h0);
        br(1'b1, 32'hFFFF_FFF0, 32'h20);
        tick(); br_clr();
        chk("wr_br_flush", {31'b0, flush}, 32'd1);
        tick();
        chk("wr_br_pc", fetch_pc, 32'h10);
        chk("wr_br_taken", taken_count, 32'd3);

        // Not-taken branches only count
        for (int i = 0; i < 5; i++) begin
            br(1'b0, 32'h400, 32'h40);
            tick();
            chk("nt_flush", {31'b0, flush}, 32'd0);
            chk("nt_pc", fetch_pc, 32'h14 + 32'(4 * i));
        end
        br_clr();
        chk("nt_branch", branch_count, 32'd9);
        chk("nt_taken", taken_count, 32'd3);

        // br_valid during REDIRECT is ignored
        br(1'b1, 32'h40, 32'h10);
        tick();
        br(1'b1, 32'h300, 32'h0);
        tick(); br_clr();
        chk("rd_ign_branch", branch_count, 32'd10);
        chk("rd_ign_taken", taken_count, 32'd4);
        chk("rd_ign_pc", fetch_pc, 32'h50);
        chk("rd_ign_flush", {31'b0, flush}, 32'd0);

        // Reset while a trap is pending discards it
        br(1'b1, 32'h200, 32'h6);
        tick(); br_clr();
        chk("pre_rst_trap", {31'b0, trap_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_trap", {31'b0, trap_valid}, 32'd0);
        chk("mid_rst_flush", {31'b0, flush}, 32'd0);
        chk("mid_rst_pc", fetch_pc, 32'h100);
        chk("mid_rst_branch", branch_count, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
